// File: rtl/ahb_arbiter.sv
// Four-master AHB arbiter: round-robin grant, parking on DEF_MASTER, fixed-length burst tracking.
// Locked transfers (LOCK state, hmastlock) are built only when AHB_ARB_LOCK_EN is defined.
module ahb_arbiter #(
  parameter int DEF_MASTER = 0
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic [3:0] hbusreq,
  input  logic [3:0] hlock,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  output logic [3:0] hgrant,
  output logic [1:0] hmaster,
  output logic       hmastlock
);

  typedef enum logic [1:0] {PARK, OWN, BURST, LOCK} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [1:0] DEF_IDX   = 2'(DEF_MASTER);
  localparam logic [3:0] DEF_GRANT = 4'b0001 << DEF_IDX;

  state_t     state;
  logic [3:0] beat_cnt;
  logic [3:0] burst_len;
  logic [1:0] grant_idx;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       win_found;
  logic       arb_point;
  logic       lock_hold;

  // Beats remaining after the NONSEQ of a fixed-length burst; zero for SINGLE/INCR.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    burst_len = 4'd0;
    case (hburst[2:1])
      2'b01:   burst_len = 4'd3;
      2'b10:   burst_len = 4'd7;
      2'b11:   burst_len = 4'd15;
      default: burst_len = 4'd0;
    endcase
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < 4; i++)
      if (hgrant[i]) grant_idx = 2'(i);
  end

  // Round robin from hmaster+1; scanning the far end first lets the nearest requester win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    cand      = hmaster;
    for (int k = 4; k >= 1; k--) begin
      cand = hmaster + 2'(k);
      if (hbusreq[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    arb_point = hready && (state == PARK || htrans == TR_IDLE ||
                (htrans == TR_NONSEQ && hburst == HB_SINGLE) ||
                (state == OWN && hburst == HB_INCR && !hbusreq[hmaster]) ||
                (state == BURST && htrans == TR_NONSEQ) ||
                (state == BURST && htrans == TR_SEQ && beat_cnt == 4'd1));
  end

`ifdef AHB_ARB_LOCK_EN
  assign lock_hold = hlock[hmaster];
`else
  logic unused_hlock;
  assign unused_hlock = ^hlock;
  assign lock_hold    = 1'b0;
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= PARK;
      hgrant    <= DEF_GRANT;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
      beat_cnt  <= 4'd0;
    end else if (hready) begin
      // NOTE: non-blocking so hmaster/hmastlock see the grant from before this edge.
      hmaster <= grant_idx;
`ifdef AHB_ARB_LOCK_EN
      hmastlock <= hlock[grant_idx];
`else
      hmastlock <= 1'b0;
`endif
      if (arb_point) begin
        beat_cnt <= 4'd0;
        if (lock_hold) begin
          state  <= LOCK;
          hgrant <= 4'b0001 << hmaster;
        end else if (win_found) begin
          state  <= OWN;
          hgrant <= 4'b0001 << win_idx;
        end else begin
          state  <= PARK;
          hgrant <= DEF_GRANT;
        end
      end else if (state == BURST) begin
        // BUSY holds the count; only accepted SEQ beats consume it.
        if (htrans == TR_SEQ) beat_cnt <= beat_cnt - 4'd1;
      end else if (state == OWN && htrans == TR_NONSEQ && burst_len != 4'd0) begin
        state    <= BURST;
        beat_cnt <= burst_len;
      end
    end
  end

endmodule
